post_adder_stage: RTL

Post-adder/subtractor stage of the DSP48A1 slice, directly downstream of `carry_mux`. It has three parts:
- an optional CYI register on the selected carry-in;
- a 48-bit Z ± (X + CIN) adder/subtractor;
- optional P and CARRYOUT registers, which drive the slice outputs P/PCOUT and CARRYOUT/CARRYOUTF.

All three registers are individually bypassable by parameter, so the slice can be configured for 0–2 cycles of carry/result latency.

---
 rtl/dsp48a1_pkg.sv | 14 +
 rtl/dsp_pipe_reg.sv | 37 +++
 rtl/post_adder_stage.sv | 79 +++++++
 3 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 slice model.
package dsp48a1_pkg;

    localparam int DSP_WIDTH = 48;

    // OPMODE bit positions
    localparam int OPM_SUB      = 7;
    localparam int OPM_CARRYSEL = 5;

    // Register stage configuration values
    localparam int REG_BYPASS = 0;
    localparam int REG_ON     = 1;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register with clock enable, synchronous clear and async clear.
// A bypassed instance holds no state and passes d straight through to q.
module dsp_pipe_reg
    import dsp48a1_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int REG   = REG_ON
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (REG != REG_BYPASS) begin : g_reg
            // Async clear beats sync clear, sync clear beats enable
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (rst) begin
                    q <= '0;
                end else if (ce) begin
                    q <= d;
                end
            end
        end else begin : g_bypass
            // Control inputs have no meaning without state
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, ce, rst};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/post_adder_stage.sv
// Post-adder/subtractor of the DSP48A1 slice: optional CYI register on the
// carry-in, Z +/- (X + CIN) at WIDTH+1 bits, optional P and CYO registers.
module post_adder_stage
    import dsp48a1_pkg::*;
#(
    parameter int WIDTH       = DSP_WIDTH,
    parameter int CARRYINREG  = REG_ON,
    parameter int CARRYOUTREG = REG_ON,
    parameter int PREG        = REG_ON
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CARRYIN_MUX,
    input  logic             CECARRYIN,
    input  logic             RSTCARRYIN,
    input  logic             CEP,
    input  logic             RSTP,
    input  logic             OPMODE7,
    input  logic [WIDTH-1:0] X_IN,
    input  logic [WIDTH-1:0] Z_IN,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] PCOUT,
    output logic             CARRYOUT,
    output logic             CARRYOUTF
);

    logic             cin;
    logic [WIDTH:0]   x_cin;
    logic [WIDTH:0]   z_ext;
    logic [WIDTH:0]   res;
    logic [WIDTH-1:0] p_q;
    logic             co_q;

    dsp_pipe_reg #(.WIDTH(1), .REG(CARRYINREG)) u_cyi (
        .clk   (CLK),
        .rst_n (RST_N),
        .ce    (CECARRYIN),
        .rst   (RSTCARRYIN),
        .d     (CARRYIN_MUX),
        .q     (cin)
    );

    // X + CIN cannot overflow WIDTH+1 bits, so the borrow is exact
    assign x_cin = {1'b0, X_IN} + {{WIDTH{1'b0}}, cin};
    assign z_ext = {1'b0, Z_IN};

    // Top bit of the WIDTH+1 result is carry on add, borrow on subtract
    always_comb begin
        res = z_ext + x_cin;
        if (OPMODE7) begin
            res = z_ext - x_cin;
        end
    end

    dsp_pipe_reg #(.WIDTH(WIDTH), .REG(PREG)) u_preg (
        .clk   (CLK),
        .rst_n (RST_N),
        .ce    (CEP),
        .rst   (RSTP),
        .d     (res[WIDTH-1:0]),
        .q     (p_q)
    );

    // CYO shares enable and sync reset with CYI
    dsp_pipe_reg #(.WIDTH(1), .REG(CARRYOUTREG)) u_cyo (
        .clk   (CLK),
        .rst_n (RST_N),
        .ce    (CECARRYIN),
        .rst   (RSTCARRYIN),
        .d     (res[WIDTH]),
        .q     (co_q)
    );

    assign P         = p_q;
    assign PCOUT     = p_q;
    assign CARRYOUT  = co_q;
    assign CARRYOUTF = co_q;

endmodule
